// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared types and constants for the memory port arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int c_DEFAULT_BURST_LEN = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DR   = 2'd2,
    OWN_DW   = 2'd3
  } mem_owner_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } arb_state_e;

  // Rotation order IF -> DR -> DW -> IF
  function automatic mem_owner_e next_owner(input mem_owner_e o);
    case (o)
      OWN_IF:  return OWN_DR;
      OWN_DR:  return OWN_DW;
      default: return OWN_IF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : External memory port bundle (command, write and read channels).
// Revision: 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_wvalid;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata,
    input  mem_ack, mem_wready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata,
    output mem_ack, mem_wready, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pick
// Brief   : Combinational winner select; ARB_ROUND_ROBIN_EN selects rotating
//           priority from ptr, otherwise fixed DW > DR > IF.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] req,    // {dw, dr, if}
  input  mem_owner_e ptr,
  output mem_owner_e winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = OWN_NONE;
    case (ptr)
      OWN_DR: begin
        if (req[1])      winner = OWN_DR;
        else if (req[2]) winner = OWN_DW;
        else if (req[0]) winner = OWN_IF;
      end
      OWN_DW: begin
        if (req[2])      winner = OWN_DW;
        else if (req[0]) winner = OWN_IF;
        else if (req[1]) winner = OWN_DR;
      end
      default: begin
        if (req[0])      winner = OWN_IF;
        else if (req[1]) winner = OWN_DR;
        else if (req[2]) winner = OWN_DW;
      end
    endcase
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    winner = OWN_NONE;
    if (req[2])      winner = OWN_DW;
    else if (req[1]) winner = OWN_DR;
    else if (req[0]) winner = OWN_IF;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one memory port among IF refill, DR refill and DW writeback.
//           Optional ARB_ROUND_ROBIN_EN enables rotating grant priority.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = c_DEFAULT_BURST_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         if_req,
  input  logic                         dr_req,
  input  logic                         dw_req,
  input  logic [ADDR_W-1:0]            if_addr,
  input  logic [ADDR_W-1:0]            dr_addr,
  input  logic [ADDR_W-1:0]            dw_addr,
  input  logic                         if_cancel,
  output logic                         if_busy,
  output logic                         dr_busy,
  output logic                         dw_busy,
  output logic                         if_finished,
  output logic                         dr_finished,
  output logic                         dw_finished,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         if_rd_valid,
  output logic                         dr_rd_valid,
  output logic [$clog2(BURST_LEN)-1:0] rd_beat,
  input  logic [DATA_W-1:0]            dw_wdata,
  output logic                         dw_wnext,
  mem_port_arbiter_if.master           mem
);

  localparam int                 c_CNT_W = $clog2(BURST_LEN);
  localparam int                 c_OFF_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0]  c_ALIGN = ~((ADDR_W'(1) << c_OFF_W) - ADDR_W'(1));

  arb_state_e          r_state, w_state_nxt;
  mem_owner_e          r_owner, r_ptr, w_winner;
  logic [ADDR_W-1:0]   r_addr, w_grant_addr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_cancel;
  logic                w_active, w_beat;
  logic [2:0]          w_req_vec;

  // A fetch being redirected in the same cycle must not win the port
  assign w_req_vec = {dw_req, dr_req, if_req & ~if_cancel};

  mem_arb_pick u_pick (
    .req    (w_req_vec),
    .ptr    (r_ptr),
    .winner (w_winner)
  );

  always_comb begin
    w_grant_addr = '0;
    case (w_winner)
      OWN_IF:  w_grant_addr = if_addr;
      OWN_DR:  w_grant_addr = dr_addr;
      OWN_DW:  w_grant_addr = dw_addr;
      default: w_grant_addr = '0;
    endcase
  end

  assign w_beat = ((r_state == READ) && mem.mem_rvalid) ||
                  ((r_state == WRITE) && mem.mem_wready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_wvalid = 1'b0;
    mem.mem_wdata  = '0;
    rd_data        = '0;
    if_rd_valid    = 1'b0;
    dr_rd_valid    = 1'b0;
    dw_wnext       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_winner != OWN_NONE) w_state_nxt = CMD;
      end
      CMD: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (r_owner == OWN_DW);
        if (mem.mem_ack) w_state_nxt = (r_owner == OWN_DW) ? WRITE : READ;
      end
      READ: begin
        if (mem.mem_rvalid) begin
          rd_data     = mem.mem_rdata;
          // live cancel also hides the beat it arrives with
          if_rd_valid = (r_owner == OWN_IF) && !r_cancel && !if_cancel;
          dr_rd_valid = (r_owner == OWN_DR);
          if (r_cnt == c_LAST) w_state_nxt = DONE;
        end
      end
      WRITE: begin
        mem.mem_wvalid = 1'b1;
        mem.mem_wdata  = dw_wdata;
        if (mem.mem_wready) begin
          dw_wnext = 1'b1;
          if (r_cnt == c_LAST) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner  <= OWN_NONE;
      r_ptr    <= OWN_IF;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_cancel <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cancel <= 1'b0;
          if (w_winner != OWN_NONE) begin
            r_owner <= w_winner;
            r_addr  <= w_grant_addr & c_ALIGN;
            r_ptr   <= next_owner(w_winner);
          end
        end
        CMD:  if (mem.mem_ack) r_cnt <= '0;
        DONE: r_owner <= OWN_NONE;
        default: if (w_beat) r_cnt <= r_cnt + 1'b1;
      endcase
      if (((r_state == CMD) || (r_state == READ)) && (r_owner == OWN_IF) && if_cancel)
        r_cancel <= 1'b1;
    end
  end

  assign w_active      = (r_state == CMD) || (r_state == READ) || (r_state == WRITE);
  assign if_busy       = w_active && (r_owner == OWN_IF) && !r_cancel;
  assign dr_busy       = w_active && (r_owner == OWN_DR);
  assign dw_busy       = w_active && (r_owner == OWN_DW);
  assign if_finished   = (r_state == DONE) && (r_owner == OWN_IF) && !r_cancel;
  assign dr_finished   = (r_state == DONE) && (r_owner == OWN_DR);
  assign dw_finished   = (r_state == DONE) && (r_owner == OWN_DW);
  assign rd_beat       = r_cnt;
  assign mem.mem_addr  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              if_req = 1'b0, dr_req = 1'b0, dw_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, dr_addr = '0, dw_addr = '0;
  logic              if_cancel = 1'b0;
  logic              if_busy, dr_busy, dw_busy;
  logic              if_finished, dr_finished, dw_finished;
  logic [DATA_W-1:0] rd_data;
  logic              if_rd_valid, dr_rd_valid;
  logic [2:0]        rd_beat;
  logic [DATA_W-1:0] dw_wdata = '0;
  logic              dw_wnext;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .dr_req(dr_req), .dw_req(dw_req),
    .if_addr(if_addr), .dr_addr(dr_addr), .dw_addr(dw_addr),
    .if_cancel(if_cancel),
    .if_busy(if_busy), .dr_busy(dr_busy), .dw_busy(dw_busy),
    .if_finished(if_finished), .dr_finished(dr_finished), .dw_finished(dw_finished),
    .rd_data(rd_data), .if_rd_valid(if_rd_valid), .dr_rd_valid(dr_rd_valid),
    .rd_beat(rd_beat), .dw_wdata(dw_wdata), .dw_wnext(dw_wnext),
    .mem(mem)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called during the first CMD cycle: ack, then 8 back-to-back beats; returns in DONE
  task automatic serve(input bit wr);
    mem.mem_ack = 1'b1;
    step();
    mem.mem_ack = 1'b0;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (wr) mem.mem_wready = 1'b1;
      else begin
        mem.mem_rvalid = 1'b1;
        mem.mem_rdata  = 64'(i);
      end
      step();
    end
    mem.mem_wready = 1'b0;
    mem.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    mem.mem_ack = 1'b0; mem.mem_wready = 1'b1; mem.mem_rvalid = 1'b1;
    mem.mem_rdata = 64'hDEAD_BEEF;
    step(); step(); #1;
    n_total++; if ({if_busy, dr_busy, dw_busy} !== 3'b000) $display("FAIL reset_busy got %b want 000", {if_busy, dr_busy, dw_busy}); else n_pass++;
    n_total++; if ({if_finished, dr_finished, dw_finished} !== 3'b000) $display("FAIL reset_finished got %b want 000", {if_finished, dr_finished, dw_finished}); else n_pass++;
    n_total++; if ({mem.mem_req, mem.mem_we, mem.mem_wvalid, dw_wnext} !== 4'b0000) $display("FAIL reset_mem_ctl got %b want 0000", {mem.mem_req, mem.mem_we, mem.mem_wvalid, dw_wnext}); else n_pass++;
    n_total++; if ({if_rd_valid, dr_rd_valid} !== 2'b00 || rd_data !== 64'h0) $display("FAIL reset_rd got v=%b d=%h want 0/0", {if_rd_valid, dr_rd_valid}, rd_data); else n_pass++;
    n_total++; if (mem.mem_addr !== 64'h0 || rd_beat !== 3'd0) $display("FAIL reset_addr_beat got %h/%0d want 0/0", mem.mem_addr, rd_beat); else n_pass++;
    mem.mem_wready = 1'b0; mem.mem_rvalid = 1'b0;
    reset = 1'b1;
    step(); #1;
    n_total++; if (mem.mem_req !== 1'b0) $display("FAIL idle_no_req got %b want 0", mem.mem_req); else n_pass++;
  endtask

  task automatic test_single_fetch();
    int beat;
    int n_valid;
    step(); if_req = 1'b1; if_addr = 64'h1038; #1;
    n_total++; if (if_busy !== 1'b0 || mem.mem_req !== 1'b0) $display("FAIL fetch_idle got busy=%b req=%b want 0/0", if_busy, mem.mem_req); else n_pass++;
    step(); #1;
    n_total++; if (if_busy !== 1'b1 || mem.mem_req !== 1'b1 || mem.mem_we !== 1'b0) $display("FAIL fetch_cmd got busy=%b req=%b we=%b want 1/1/0", if_busy, mem.mem_req, mem.mem_we); else n_pass++;
    n_total++; if (mem.mem_addr !== 64'h1000) $display("FAIL fetch_addr got %h want 1000", mem.mem_addr); else n_pass++;
    step(); mem.mem_ack = 1'b1; #1;
    n_total++; if (mem.mem_req !== 1'b1) $display("FAIL fetch_cmd_hold got %b want 1", mem.mem_req); else n_pass++;
    step(); mem.mem_ack = 1'b0;
    beat = 0; n_valid = 0;
    for (int c = 0; c < 9; c++) begin
      mem.mem_rvalid = (c != 3);
      mem.mem_rdata  = 64'hA000 + 64'(beat);
      #1;
      if (c != 3) begin
        n_total++; if (if_rd_valid !== 1'b1 || rd_beat !== 3'(beat) || rd_data !== 64'hA000 + 64'(beat)) $display("FAIL fetch_beat%0d got v=%b beat=%0d d=%h want 1/%0d/%h", beat, if_rd_valid, rd_beat, rd_data, beat, 64'hA000 + 64'(beat)); else n_pass++;
        beat++;
      end else begin
        n_total++; if (if_rd_valid !== 1'b0) $display("FAIL fetch_gap got %b want 0", if_rd_valid); else n_pass++;
      end
      if (if_rd_valid) n_valid++;
      step();
    end
    mem.mem_rvalid = 1'b0; #1;
    n_total++; if (if_finished !== 1'b1 || if_busy !== 1'b0) $display("FAIL fetch_done got fin=%b busy=%b want 1/0", if_finished, if_busy); else n_pass++;
    n_total++; if (n_valid !== 8) $display("FAIL fetch_pulses got %0d want 8", n_valid); else n_pass++;
    if_req = 1'b0;
    step(); #1;
    n_total++; if (if_finished !== 1'b0 || if_busy !== 1'b0) $display("FAIL fetch_after got fin=%b busy=%b want 0/0", if_finished, if_busy); else n_pass++;
  endtask

  task automatic test_simultaneous();
    step();
    if_req = 1'b1; dr_req = 1'b1; dw_req = 1'b1;
    if_addr = 64'h10FF; dr_addr = 64'h2077; dw_addr = 64'h3ABC; #1;
    step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b100 || mem.mem_we !== 1'b1 || mem.mem_addr !== 64'h3A80) $display("FAIL sim_first got busy=%b we=%b a=%h want 100/1/3a80", {dw_busy, dr_busy, if_busy}, mem.mem_we, mem.mem_addr); else n_pass++;
    serve(1'b1); #1;
    n_total++; if ({dw_finished, dr_finished, if_finished} !== 3'b100) $display("FAIL sim_fin1 got %b want 100", {dw_finished, dr_finished, if_finished}); else n_pass++;
    dw_req = 1'b0;
    step(); step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b010 || mem.mem_we !== 1'b0 || mem.mem_addr !== 64'h2040) $display("FAIL sim_second got busy=%b we=%b a=%h want 010/0/2040", {dw_busy, dr_busy, if_busy}, mem.mem_we, mem.mem_addr); else n_pass++;
    serve(1'b0); #1;
    n_total++; if ({dw_finished, dr_finished, if_finished} !== 3'b010) $display("FAIL sim_fin2 got %b want 010", {dw_finished, dr_finished, if_finished}); else n_pass++;
    dr_req = 1'b0;
    step(); step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b001 || mem.mem_addr !== 64'h10C0) $display("FAIL sim_third got busy=%b a=%h want 001/10c0", {dw_busy, dr_busy, if_busy}, mem.mem_addr); else n_pass++;
    serve(1'b0); #1;
    n_total++; if ({dw_finished, dr_finished, if_finished} !== 3'b001) $display("FAIL sim_fin3 got %b want 001", {dw_finished, dr_finished, if_finished}); else n_pass++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_writeback_stalls();
    int beats;
    int n_wnext;
    step(); dw_req = 1'b1; dw_addr = 64'h2040; #1;
    step(); mem.mem_wready = 1'b1; #1;
    n_total++; if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b1 || mem.mem_addr !== 64'h2040) $display("FAIL wb_cmd got req=%b we=%b a=%h want 1/1/2040", mem.mem_req, mem.mem_we, mem.mem_addr); else n_pass++;
    n_total++; if (dw_wnext !== 1'b0 || mem.mem_wvalid !== 1'b0) $display("FAIL wb_cmd_wready_ignored got wnext=%b wvalid=%b want 0/0", dw_wnext, mem.mem_wvalid); else n_pass++;
    mem.mem_ack = 1'b1;
    step(); mem.mem_ack = 1'b0;
    beats = 0; n_wnext = 0;
    for (int c = 0; c < 16; c++) begin
      mem.mem_wready = (c % 2 == 1);
      mem.mem_rvalid = (c == 2);
      dw_wdata = 64'hD000 + 64'(beats);
      #1;
      n_total++; if (dw_wnext !== mem.mem_wready || mem.mem_wvalid !== 1'b1) $display("FAIL wb_cycle%0d got wnext=%b wvalid=%b want %b/1", c, dw_wnext, mem.mem_wvalid, (c % 2 == 1)); else n_pass++;
      n_total++; if (mem.mem_wdata !== 64'hD000 + 64'(beats)) $display("FAIL wb_wdata%0d got %h want %h", c, mem.mem_wdata, 64'hD000 + 64'(beats)); else n_pass++;
      if (c == 2) begin
        n_total++; if ({if_rd_valid, dr_rd_valid} !== 2'b00 || rd_data !== 64'h0) $display("FAIL wb_rvalid_ignored got v=%b d=%h want 00/0", {if_rd_valid, dr_rd_valid}, rd_data); else n_pass++;
      end
      if (dw_wnext) n_wnext++;
      if (c % 2 == 1) beats++;
      step();
    end
    mem.mem_wready = 1'b0; mem.mem_rvalid = 1'b0; #1;
    n_total++; if (dw_finished !== 1'b1 || dw_busy !== 1'b0) $display("FAIL wb_done got fin=%b busy=%b want 1/0", dw_finished, dw_busy); else n_pass++;
    n_total++; if (n_wnext !== 8) $display("FAIL wb_wnext_count got %0d want 8", n_wnext); else n_pass++;
    dw_req = 1'b0;
    step();
  endtask

  task automatic test_cancel();
    // cancel in IDLE makes the fetch ineligible
    step(); if_req = 1'b1; if_cancel = 1'b1; #1;
    step(); if_req = 1'b0; if_cancel = 1'b0; #1;
    n_total++; if (mem.mem_req !== 1'b0 || if_busy !== 1'b0) $display("FAIL cancel_idle got req=%b busy=%b want 0/0", mem.mem_req, if_busy); else n_pass++;
    step(); if_req = 1'b1; if_addr = 64'h3000; #1;
    step(); #1;
    n_total++; if (if_busy !== 1'b1) $display("FAIL cancel_grant got %b want 1", if_busy); else n_pass++;
    mem.mem_ack = 1'b1;
    step(); mem.mem_ack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mem.mem_rvalid = 1'b1;
      mem.mem_rdata  = 64'hB000 + 64'(b);
      if_cancel = (b == 3);
      if (b >= 4) begin
        if_req = 1'b0; dr_req = 1'b1; dr_addr = 64'h4000;
      end
      #1;
      n_total++; if (if_rd_valid !== (b < 3)) $display("FAIL cancel_rdv%0d got %b want %b", b, if_rd_valid, (b < 3)); else n_pass++;
      if (b >= 4) begin
        n_total++; if (if_busy !== 1'b0 || dr_busy !== 1'b0) $display("FAIL cancel_busy%0d got if=%b dr=%b want 0/0", b, if_busy, dr_busy); else n_pass++;
      end
      step();
    end
    mem.mem_rvalid = 1'b0; if_cancel = 1'b0; #1;
    n_total++; if (if_finished !== 1'b0 || if_busy !== 1'b0 || dr_busy !== 1'b0) $display("FAIL cancel_done got fin=%b ifb=%b drb=%b want 0/0/0", if_finished, if_busy, dr_busy); else n_pass++;
    step(); #1;
    n_total++; if (dr_busy !== 1'b0) $display("FAIL cancel_idle_after got %b want 0", dr_busy); else n_pass++;
    step(); #1;
    n_total++; if (dr_busy !== 1'b1 || mem.mem_addr !== 64'h4000) $display("FAIL cancel_next_grant got busy=%b a=%h want 1/4000", dr_busy, mem.mem_addr); else n_pass++;
    serve(1'b0); #1;
    n_total++; if (dr_finished !== 1'b1) $display("FAIL cancel_dr_fin got %b want 1", dr_finished); else n_pass++;
    dr_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    step(); dw_req = 1'b1; dw_addr = 64'h5080; #1;
    step(); #1;
    mem.mem_ack = 1'b1;
    step(); mem.mem_ack = 1'b0; mem.mem_wready = 1'b1; #1;
    n_total++; if (dw_wnext !== 1'b1 || mem.mem_wvalid !== 1'b1) $display("FAIL rst_pre got wnext=%b wvalid=%b want 1/1", dw_wnext, mem.mem_wvalid); else n_pass++;
    step(); #1;
    reset = 1'b0; #1;
    n_total++; if ({dw_busy, dw_wnext, mem.mem_wvalid, mem.mem_req} !== 4'b0000) $display("FAIL rst_mid_ctl got %b want 0000", {dw_busy, dw_wnext, mem.mem_wvalid, mem.mem_req}); else n_pass++;
    n_total++; if (mem.mem_addr !== 64'h0 || rd_beat !== 3'd0) $display("FAIL rst_mid_addr got %h/%0d want 0/0", mem.mem_addr, rd_beat); else n_pass++;
    step(); dw_req = 1'b0; mem.mem_wready = 1'b0; reset = 1'b1; #1;
    step(); #1;
    n_total++; if (mem.mem_req !== 1'b0 || dw_busy !== 1'b0) $display("FAIL rst_idle got req=%b busy=%b want 0/0", mem.mem_req, dw_busy); else n_pass++;
    step(); dr_req = 1'b1; dr_addr = 64'h6048; #1;
    step(); #1;
    n_total++; if (dr_busy !== 1'b1 || mem.mem_addr !== 64'h6040) $display("FAIL rst_regrant got busy=%b a=%h want 1/6040", dr_busy, mem.mem_addr); else n_pass++;
    serve(1'b0); #1;
    n_total++; if (dr_finished !== 1'b1) $display("FAIL rst_regrant_fin got %b want 1", dr_finished); else n_pass++;
    dr_req = 1'b0;
    step();
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    step(); reset = 1'b0; #1;
    step(); reset = 1'b1;
    if_req = 1'b1; dr_req = 1'b1; dw_req = 1'b1; #1;
    step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b001) $display("FAIL rr_g1 got %b want 001", {dw_busy, dr_busy, if_busy}); else n_pass++;
    serve(1'b0);
    step(); step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b010) $display("FAIL rr_g2 got %b want 010", {dw_busy, dr_busy, if_busy}); else n_pass++;
    serve(1'b0);
    step(); step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b100) $display("FAIL rr_g3 got %b want 100", {dw_busy, dr_busy, if_busy}); else n_pass++;
    serve(1'b1);
    step(); step(); #1;
    n_total++; if ({dw_busy, dr_busy, if_busy} !== 3'b001) $display("FAIL rr_g4 got %b want 001", {dw_busy, dr_busy, if_busy}); else n_pass++;
    serve(1'b0);
    if_req = 1'b0; dr_req = 1'b0; dw_req = 1'b0;
    step();
  endtask
`endif

  initial begin
    mem.mem_ack = 1'b0; mem.mem_wready = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
    test_reset();
    test_single_fetch();
`ifndef ARB_ROUND_ROBIN_EN
    test_simultaneous();
`endif
    test_writeback_stalls();
    test_cancel();
    test_reset_mid_burst();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
